// File: rtl/video_rx_pkg.sv
// -----------------------------------------------------------------------------
// video_rx_pkg
// Shared definitions for the video frame receiver slice.
//   rx_state_e : receiver FSM states (IDLE, FRAME, LINE)
//   CRC_POLY   : CRC-16-CCITT generator polynomial
//   CRC_INIT   : CRC seed loaded at the start of every frame
// No ports (package).
// -----------------------------------------------------------------------------
package video_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      LINE  = 2'd2
   } rx_state_e;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/video_rx_crc16.sv
// -----------------------------------------------------------------------------
// video_rx_crc16
// One-step CRC-16-CCITT update over a single byte, purely combinational.
// The byte is shifted in MSB first (non-reflected CCITT form).
// Ports:
//   crc_in  [15:0] in   current CRC register value
//   data_in [7:0]  in   byte to fold in
//   crc_out [15:0] out  CRC after absorbing data_in
// -----------------------------------------------------------------------------
module video_rx_crc16
   import video_rx_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] crc_work;

   always_comb begin
      crc_work = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (crc_work[15] ^ data_in[i]) begin
            crc_work = {crc_work[14:0], 1'b0} ^ CRC_POLY;
         end else begin
            crc_work = {crc_work[14:0], 1'b0};
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/video_frame_rx.sv
// -----------------------------------------------------------------------------
// video_frame_rx
// Receives a vsync/hsync framed pixel stream, tags each in-bounds pixel with
// its (x, y) position and reports line/frame boundaries and geometry errors.
// Optional feature macro: VIDEO_RX_CRC_EN adds a CRC-16-CCITT of every frame
// (frame_crc port plus the video_rx_crc16 sub-module).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   frame_vsync           high for the whole frame
//   line_hsync            high for each active pixel
//   pix_in                pixel sampled while line_hsync=1
//   pix_valid, pix_out    registered in-bounds pixel, 1 cycle after sampling
//   x_pos, y_pos          0-based position of pix_out
//   sof, eol, eof         first pixel / line closed / frame closed strobes
//   err_line_len          with eol: line did not carry IMG_WIDTH pixels
//   err_line_cnt          with eof: frame did not carry IMG_HEIGHT lines
//   frame_cnt             completed frames, wraps
//   frame_crc             CRC of the last frame (VIDEO_RX_CRC_EN only)
// -----------------------------------------------------------------------------
module video_frame_rx
   import video_rx_pkg::*;
#(
   parameter int IMG_WIDTH  = 1280,
   parameter int IMG_HEIGHT = 720,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            frame_vsync,
   input  logic                            line_hsync,
   input  logic [DATA_WIDTH-1:0]           pix_in,
   output logic                            pix_valid,
   output logic [DATA_WIDTH-1:0]           pix_out,
   output logic [$clog2(IMG_WIDTH+1)-1:0]  x_pos,
   output logic [$clog2(IMG_HEIGHT+1)-1:0] y_pos,
   output logic                            sof,
   output logic                            eol,
   output logic                            eof,
   output logic                            err_line_len,
   output logic                            err_line_cnt,
   output logic [15:0]                     frame_cnt
`ifdef VIDEO_RX_CRC_EN
   ,
   output logic [15:0]                     frame_crc
`endif
);

   localparam int XW  = $clog2(IMG_WIDTH + 1);
   localparam int YW  = $clog2(IMG_HEIGHT + 1);
   // Internal counters get one extra code so "more than expected" stays
   // distinguishable from "exactly expected" after saturation.
   localparam int XCW = $clog2(IMG_WIDTH + 2);
   localparam int YCW = $clog2(IMG_HEIGHT + 2);
   localparam logic [XCW-1:0] X_FULL = XCW'(IMG_WIDTH);
   localparam logic [XCW-1:0] X_SAT  = XCW'(IMG_WIDTH + 1);
   localparam logic [YCW-1:0] Y_FULL = YCW'(IMG_HEIGHT);
   localparam logic [YCW-1:0] Y_SAT  = YCW'(IMG_HEIGHT + 1);

   rx_state_e             state_q, state_d;
   logic                  vsync_prev_q, vsync_prev_d;
   logic [XCW-1:0]        x_cnt_q, x_cnt_d;      // pixels accepted on open line
   logic [YCW-1:0]        y_cnt_q, y_cnt_d;      // lines closed in this frame
   logic                  pix_valid_q, pix_valid_d;
   logic [DATA_WIDTH-1:0] pix_out_q, pix_out_d;
   logic [XW-1:0]         x_pos_q, x_pos_d;
   logic [YW-1:0]         y_pos_q, y_pos_d;
   logic                  sof_q, sof_d;
   logic                  eol_q, eol_d;
   logic                  eof_q, eof_d;
   logic                  err_line_len_q, err_line_len_d;
   logic                  err_line_cnt_q, err_line_cnt_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;

   // Per-cycle decisions of the FSM, consumed by the datapath below.
   logic                  accept;
   logic [XCW-1:0]        acc_x;
   logic                  line_close;
   logic                  frame_close;
   logic [YCW-1:0]        lines_closed;

`ifdef VIDEO_RX_CRC_EN
   logic [15:0]           crc_q, crc_d;
   logic [15:0]           frame_crc_q, frame_crc_d;
   logic [15:0]           crc_next;
   logic [7:0]            crc_byte;

   // Pixels narrower than a byte are zero-extended, wider ones use the low byte.
   generate
      if (DATA_WIDTH >= 8) begin : g_byte_lo
         assign crc_byte = pix_in[7:0];
      end else begin : g_byte_ext
         assign crc_byte = {{(8 - DATA_WIDTH){1'b0}}, pix_in};
      end
   endgenerate

   video_rx_crc16 u_crc16 (
      .crc_in  (crc_q),
      .data_in (crc_byte),
      .crc_out (crc_next)
   );
`endif

   always_comb begin
      state_d        = state_q;
      vsync_prev_d   = frame_vsync;
      x_cnt_d        = x_cnt_q;
      y_cnt_d        = y_cnt_q;
      pix_valid_d    = 1'b0;
      pix_out_d      = pix_out_q;
      x_pos_d        = x_pos_q;
      y_pos_d        = y_pos_q;
      sof_d          = 1'b0;
      eol_d          = 1'b0;
      eof_d          = 1'b0;
      err_line_len_d = 1'b0;
      err_line_cnt_d = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      accept         = 1'b0;
      acc_x          = x_cnt_q;
      line_close     = 1'b0;
      frame_close    = 1'b0;
      lines_closed   = y_cnt_q;
`ifdef VIDEO_RX_CRC_EN
      crc_d          = crc_q;
      frame_crc_d    = frame_crc_q;
`endif

      case (state_q)
         IDLE: begin
            // Only a genuine rising edge opens a frame; hsync is ignored here.
            if (frame_vsync && !vsync_prev_q) begin
               state_d = FRAME;
               x_cnt_d = '0;
               y_cnt_d = '0;
`ifdef VIDEO_RX_CRC_EN
               crc_d   = CRC_INIT;
`endif
            end
         end
         FRAME: begin
            if (!frame_vsync) begin
               state_d     = IDLE;
               frame_close = 1'b1;
            end else if (line_hsync) begin
               state_d = LINE;
               accept  = 1'b1;
               acc_x   = '0;
            end
         end
         LINE: begin
            // vsync dropping closes the open line and the frame together;
            // a pixel presented in that cycle is not part of the frame.
            if (!frame_vsync) begin
               state_d     = IDLE;
               line_close  = 1'b1;
               frame_close = 1'b1;
            end else if (line_hsync) begin
               accept = 1'b1;
            end else begin
               state_d    = FRAME;
               line_close = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         x_cnt_d = (acc_x == X_SAT) ? X_SAT : acc_x + XCW'(1);
         if ((acc_x < X_FULL) && (y_cnt_q < Y_FULL)) begin
            pix_valid_d = 1'b1;
            pix_out_d   = pix_in;
            x_pos_d     = acc_x[XW-1:0];
            y_pos_d     = y_cnt_q[YW-1:0];
            sof_d       = (acc_x == '0) && (y_cnt_q == '0);
`ifdef VIDEO_RX_CRC_EN
            crc_d       = crc_next;
`endif
         end
      end

      if (line_close) begin
         eol_d          = 1'b1;
         err_line_len_d = (x_cnt_q != X_FULL);
         lines_closed   = (y_cnt_q == Y_SAT) ? Y_SAT : y_cnt_q + YCW'(1);
         y_cnt_d        = lines_closed;
      end

      // lines_closed already includes a line closed in this same cycle.
      if (frame_close) begin
         eof_d          = 1'b1;
         err_line_cnt_d = (lines_closed != Y_FULL);
         frame_cnt_d    = frame_cnt_q + 16'd1;
`ifdef VIDEO_RX_CRC_EN
         frame_crc_d    = crc_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         // Treat vsync as already high so a frame in progress at reset
         // release is skipped until vsync falls and rises again.
         vsync_prev_q   <= 1'b1;
         x_cnt_q        <= '0;
         y_cnt_q        <= '0;
         pix_valid_q    <= 1'b0;
         pix_out_q      <= '0;
         x_pos_q        <= '0;
         y_pos_q        <= '0;
         sof_q          <= 1'b0;
         eol_q          <= 1'b0;
         eof_q          <= 1'b0;
         err_line_len_q <= 1'b0;
         err_line_cnt_q <= 1'b0;
         frame_cnt_q    <= '0;
`ifdef VIDEO_RX_CRC_EN
         crc_q          <= CRC_INIT;
         frame_crc_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         vsync_prev_q   <= vsync_prev_d;
         x_cnt_q        <= x_cnt_d;
         y_cnt_q        <= y_cnt_d;
         pix_valid_q    <= pix_valid_d;
         pix_out_q      <= pix_out_d;
         x_pos_q        <= x_pos_d;
         y_pos_q        <= y_pos_d;
         sof_q          <= sof_d;
         eol_q          <= eol_d;
         eof_q          <= eof_d;
         err_line_len_q <= err_line_len_d;
         err_line_cnt_q <= err_line_cnt_d;
         frame_cnt_q    <= frame_cnt_d;
`ifdef VIDEO_RX_CRC_EN
         crc_q          <= crc_d;
         frame_crc_q    <= frame_crc_d;
`endif
      end
   end

   assign pix_valid    = pix_valid_q;
   assign pix_out      = pix_out_q;
   assign x_pos        = x_pos_q;
   assign y_pos        = y_pos_q;
   assign sof          = sof_q;
   assign eol          = eol_q;
   assign eof          = eof_q;
   assign err_line_len = err_line_len_q;
   assign err_line_cnt = err_line_cnt_q;
   assign frame_cnt    = frame_cnt_q;
`ifdef VIDEO_RX_CRC_EN
   assign frame_crc    = frame_crc_q;
`endif

endmodule

// File: tb/tb_video_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_video_frame_rx
// Self-checking bench for video_frame_rx (IMG_WIDTH=8, IMG_HEIGHT=4).
// Frames are described as a list of line lengths; the reference model turns
// that description into expected pixel / eol / eof events stamped with the
// clock edge at which they must appear, and a negedge monitor matches every
// DUT strobe against those queues. With VIDEO_RX_CRC_EN the frame CRC is
// checked as well, plus a second instance on the "123456789" check string.
// -----------------------------------------------------------------------------
module tb_video_frame_rx;

   localparam int W = 8;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_vsync = 1'b1;
   logic        line_hsync = 1'b0;
   logic [7:0]  pix_in = 8'h00;
   logic        pix_valid;
   logic [7:0]  pix_out;
   logic [3:0]  x_pos;
   logic [2:0]  y_pos;
   logic        sof, eol, eof, err_line_len, err_line_cnt;
   logic [15:0] frame_cnt;
`ifdef VIDEO_RX_CRC_EN
   logic [15:0] frame_crc;
`endif

   video_frame_rx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_vsync  (frame_vsync),
      .line_hsync   (line_hsync),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_out      (pix_out),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .sof          (sof),
      .eol          (eol),
      .eof          (eof),
      .err_line_len (err_line_len),
      .err_line_cnt (err_line_cnt),
      .frame_cnt    (frame_cnt)
`ifdef VIDEO_RX_CRC_EN
      ,
      .frame_crc    (frame_crc)
`endif
   );

`ifdef VIDEO_RX_CRC_EN
   // Known-answer instance: one 9-pixel line per frame.
   logic        v2 = 1'b0, h2 = 1'b0;
   logic [7:0]  p2 = 8'h00;
   logic        pv2, sof2, eol2, eof2, el2, ec2;
   logic [7:0]  po2;
   logic [3:0]  x2;
   logic [0:0]  y2;
   logic [15:0] fc2, crc2;

   video_frame_rx #(.IMG_WIDTH(9), .IMG_HEIGHT(1), .DATA_WIDTH(8)) u_dut_kat (
      .clk (clk), .rst_n (rst_n), .frame_vsync (v2), .line_hsync (h2), .pix_in (p2),
      .pix_valid (pv2), .pix_out (po2), .x_pos (x2), .y_pos (y2), .sof (sof2),
      .eol (eol2), .eof (eof2), .err_line_len (el2), .err_line_cnt (ec2),
      .frame_cnt (fc2), .frame_crc (crc2)
   );
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int c; int x; int y; logic [7:0] d; logic s; } pix_t;
   typedef struct { int c; logic e; } eol_t;
   typedef struct { int c; logic e; logic [15:0] n; logic [15:0] crc; } eof_t;

   pix_t pq[$];
   eol_t lq[$];
   eof_t fq[$];
   logic [15:0] model_fcnt = 16'd0;
   int line_len [8];

   // Whole-byte-at-a-time CRC-16-CCITT, seed supplied by the caller.
   function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   // Drive one cycle of inputs; returns the index of the edge that samples them.
   task automatic drive(input logic v, input logic h, input logic [7:0] p, output int c);
      frame_vsync = v;
      line_hsync  = h;
      pix_in      = p;
      @(posedge clk);
      #1;
      c = cyc;
   endtask

   task automatic push_eof(input int c, input int nlines, input logic [15:0] crc);
      model_fcnt++;
      fq.push_back('{c, (nlines != H), model_fcnt, crc});
   endtask

   // One frame: nlines lines with lengths line_len[], gap low-hsync cycles
   // between lines; cut drops vsync while the last line still has hsync high.
   task automatic run_frame(input int nlines, input bit cut, input bit seq, input int gap);
      int c;
      logic [7:0] d;
      logic [7:0] sq;
      logic [15:0] crc;
      sq  = 8'h00;
      crc = 16'hFFFF;
      repeat (2) drive(1'b0, 1'($urandom), 8'($urandom), c);   // idle, stray hsync
      drive(1'b1, 1'b0, 8'h00, c);                               // vsync rises
      repeat (gap - 1) drive(1'b1, 1'b0, 8'h00, c);
      for (int i = 0; i < nlines; i++) begin
         for (int j = 0; j < line_len[i]; j++) begin
            d = seq ? sq : 8'($urandom);
            sq++;
            drive(1'b1, 1'b1, d, c);
            if (j < W && i < H) begin
               pq.push_back('{c, j, i, d, (i == 0 && j == 0)});
               crc = crc_model(crc, d);
            end
         end
         if (cut && i == nlines - 1) begin
            drive(1'b0, 1'b1, 8'($urandom), c);
            lq.push_back('{c, (line_len[i] != W)});
            push_eof(c, nlines, crc);
            return;
         end
         drive(1'b1, 1'b0, 8'h00, c);
         lq.push_back('{c, (line_len[i] != W)});
         repeat (gap - 1) drive(1'b1, 1'b0, 8'h00, c);
      end
      drive(1'b0, 1'b0, 8'h00, c);
      push_eof(c, nlines, crc);
   endtask

   task automatic check_reset_state();
      check_val("rst_pix_valid", pix_valid, 0);
      check_val("rst_pix_out", pix_out, 0);
      check_val("rst_x_pos", x_pos, 0);
      check_val("rst_y_pos", y_pos, 0);
      check_val("rst_strobes", {sof, eol, eof, err_line_len, err_line_cnt}, 0);
      check_val("rst_frame_cnt", frame_cnt, 0);
`ifdef VIDEO_RX_CRC_EN
      check_val("rst_frame_crc", frame_crc, 0);
`endif
   endtask

   // ---------------- monitor ----------------
   pix_t pe;
   eol_t le;
   eof_t fe;

   always @(negedge clk) begin
      if (pix_valid === 1'b1) begin
         if (pq.size() == 0) check_val("pix_unexpected", 1, 0);
         else begin
            pe = pq.pop_front();
            check_val("pix_edge", cyc, pe.c);
            check_val("pix_data", pix_out, pe.d);
            check_val("pix_x", x_pos, pe.x);
            check_val("pix_y", y_pos, pe.y);
            check_val("pix_sof", sof, pe.s);
         end
      end else if (sof === 1'b1) check_val("sof_without_pixel", 1, 0);

      if (eol === 1'b1) begin
         if (lq.size() == 0) check_val("eol_unexpected", 1, 0);
         else begin
            le = lq.pop_front();
            check_val("eol_edge", cyc, le.c);
            check_val("err_line_len", err_line_len, le.e);
         end
      end else if (err_line_len === 1'b1) check_val("err_len_without_eol", 1, 0);

      if (eof === 1'b1) begin
         if (fq.size() == 0) check_val("eof_unexpected", 1, 0);
         else begin
            fe = fq.pop_front();
            check_val("eof_edge", cyc, fe.c);
            check_val("err_line_cnt", err_line_cnt, fe.e);
            check_val("frame_cnt", frame_cnt, fe.n);
`ifdef VIDEO_RX_CRC_EN
            check_val("frame_crc", frame_crc, fe.crc);
`endif
            $display("frame closed at edge %0d: frame_cnt=%0d err_line_cnt=%0b", cyc, frame_cnt, err_line_cnt);
         end
      end else if (err_line_cnt === 1'b1) check_val("err_cnt_without_eof", 1, 0);
   end

   // ---------------- stimulus ----------------
   initial begin
      int c;
      int nl;
      // Reset with vsync already high, then keep it high: must be ignored.
      repeat (3) drive(1'b1, 1'b0, 8'h00, c);
      check_reset_state();
      rst_n = 1'b1;
      repeat (5) drive(1'b1, 1'($urandom), 8'($urandom), c);

      // Nominal frame, sequential pixels 0x00..0x1F.
      line_len = '{8, 8, 8, 8, 8, 8, 8, 8};
      run_frame(4, 1'b0, 1'b1, 3);
      // Short line 2.
      line_len = '{8, 8, 7, 8, 8, 8, 8, 8};
      run_frame(4, 1'b0, 1'b0, 3);
      // Long line 1.
      line_len = '{8, 10, 8, 8, 8, 8, 8, 8};
      run_frame(4, 1'b0, 1'b0, 3);
      // vsync drops during line 2 with hsync high.
      line_len = '{8, 8, 8, 8, 8, 8, 8, 8};
      run_frame(3, 1'b1, 1'b0, 3);
      // Zero-length frame.
      run_frame(0, 1'b0, 1'b0, 3);

      // Reset in the middle of line 1.
      repeat (2) drive(1'b0, 1'b0, 8'h00, c);
      drive(1'b1, 1'b0, 8'h00, c);
      repeat (2) drive(1'b1, 1'b0, 8'h00, c);
      for (int j = 0; j < W; j++) begin
         drive(1'b1, 1'b1, 8'(j + 8'h40), c);
         pq.push_back('{c, j, 0, 8'(j + 8'h40), (j == 0)});
      end
      drive(1'b1, 1'b0, 8'h00, c);
      lq.push_back('{c, 1'b0});
      repeat (2) drive(1'b1, 1'b0, 8'h00, c);
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, 1'b1, 8'(j + 8'h60), c);
         pq.push_back('{c, j, 1, 8'(j + 8'h60), 1'b0});
      end
      rst_n = 1'b0;
      repeat (2) drive(1'b1, 1'b1, 8'hAA, c);
      model_fcnt = 16'd0;
      check_reset_state();
      rst_n = 1'b1;
      repeat (4) drive(1'b1, 1'($urandom), 8'($urandom), c);
      line_len = '{8, 8, 8, 8, 8, 8, 8, 8};
      run_frame(4, 1'b0, 1'b0, 3);

      // Randomized frames.
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 8; i++)
            line_len[i] = ($urandom_range(0, 1) == 1) ? W : $urandom_range(5, 10);
         nl = $urandom_range(0, 5);
         run_frame(nl, (nl > 0) && ($urandom_range(0, 3) == 0), 1'b0, $urandom_range(1, 4));
      end

      repeat (3) drive(1'b0, 1'b0, 8'h00, c);
      check_val("pix_missing", pq.size(), 0);
      check_val("eol_missing", lq.size(), 0);
      check_val("eof_missing", fq.size(), 0);
      check_val("final_frame_cnt", frame_cnt, model_fcnt);

`ifdef VIDEO_RX_CRC_EN
      // "123456789" on a 9x1 frame -> CRC-16-CCITT (0xFFFF seed) = 0x29B1.
      v2 = 1'b0; drive(1'b0, 1'b0, 8'h00, c);
      v2 = 1'b1; drive(1'b0, 1'b0, 8'h00, c);
      for (int k = 0; k < 9; k++) begin
         h2 = 1'b1;
         p2 = 8'h31 + 8'(k);
         drive(1'b0, 1'b0, 8'h00, c);
      end
      h2 = 1'b0; drive(1'b0, 1'b0, 8'h00, c);
      v2 = 1'b0; drive(1'b0, 1'b0, 8'h00, c);
      check_val("kat_eof_flags", {eof2, ec2}, 2'b10);
      check_val("kat_frame_crc", crc2, 16'h29B1);
      check_val("kat_frame_cnt", fc2, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/video_frame_rx.md
VIDEO_FRAME_RX -- requirements
Module: video_frame_rx

Interface
REQ-001 Parameter IMG_WIDTH, default 1280, meaning pixels per active line.
REQ-002 Parameter IMG_HEIGHT, default 720, meaning active lines per frame.
REQ-003 Parameter DATA_WIDTH, default 8, meaning pixel width in bits.
REQ-004 clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 frame_vsync  in  1  frame envelope; high for the whole frame.
REQ-007 line_hsync  in  1  line valid; high for each active pixel.
REQ-008 pix_in  in  DATA_WIDTH  pixel sampled when line_hsync=1.
REQ-009 pix_valid  out  1  registered accepted-pixel strobe.
REQ-010 pix_out  out  DATA_WIDTH  registered pixel, valid with pix_valid.
REQ-011 x_pos  out  clog2(IMG_WIDTH+1)  column of pix_out, 0-based.
REQ-012 y_pos  out  clog2(IMG_HEIGHT+1)  line of pix_out, 0-based.
REQ-013 sof / eol / eof  out  1 each  one-cycle strobes: first pixel of frame, line closed, frame closed.
REQ-014 err_line_len / err_line_cnt  out  1 each  one-cycle error strobes.
REQ-015 frame_cnt  out  16  completed frames, wraps at 0xFFFF->0.
REQ-016 frame_crc  out  16  CRC of last frame (only with VIDEO_RX_CRC_EN).

Function
REQ-017 FSM states SHALL be IDLE, FRAME, LINE.
REQ-018 IDLE->FRAME only on vsync rising edge (vsync=1, registered previous vsync=0); vsync already high after reset SHALL be ignored until it falls and rises.
REQ-019 FRAME->LINE when hsync=1; that cycle's pixel is accepted with x=0.
REQ-020 LINE->FRAME when hsync=0; eol pulses next cycle; err_line_len pulses with eol if accepted count != IMG_WIDTH; y increments.
REQ-021 FRAME or LINE ->IDLE when vsync=0; open line closed same cycle (eol, length check); eof pulses; err_line_cnt pulses with eof if closed lines != IMG_HEIGHT; frame_cnt increments.
REQ-022 Accepted pixel appears on pix_out/pix_valid exactly 1 cycle after sampling; x_pos/y_pos aligned with it.
REQ-023 sof SHALL coincide with pix_valid of pixel (0,0) only.
REQ-024 Pixels with x >= IMG_WIDTH or y >= IMG_HEIGHT SHALL not assert pix_valid; counters saturate, error reported at eol/eof.
REQ-025 hsync while in IDLE SHALL be ignored entirely.
REQ-026 Zero-length frame (vsync pulse, no hsync): eof and err_line_cnt pulse, frame_cnt increments.

Reset
REQ-027 On rst_n=0: state IDLE; all strobes, pix_valid, x_pos, y_pos, frame_cnt, frame_crc = 0; pix_out = 0.
REQ-028 Reset mid-frame SHALL discard the frame with no eol/eof/error strobes; capture resumes on the next vsync rising edge.

Configuration
REQ-029 Macro VIDEO_RX_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over accepted pixels, LSB-aligned per byte, latched to frame_crc on eof.
REQ-030 Macro absent: frame_crc port SHALL not exist and no CRC logic is built.

Structure
REQ-031 Package video_rx_pkg SHALL hold the FSM state enum, CRC_POLY, CRC_INIT constants.
REQ-032 Sub-module video_rx_crc16 (one-step byte update, combinational) SHALL be instantiated only under VIDEO_RX_CRC_EN.

Verification (IMG_WIDTH=8, IMG_HEIGHT=4, ROW gap 3 cycles)
REQ-033 Nominal frame, pixels 0x00..0x1F -> 32 pix_valid, sof once, 4 eol, 1 eof, no errors, frame_cnt=1.
REQ-034 Line 2 hsync high 7 cycles -> eol for line 2 with err_line_len, 31 pix_valid total.
REQ-035 Line 1 hsync high 10 cycles -> 8 pixels on line 1 valid, err_line_len at its eol.
REQ-036 vsync falls after 3 lines, while hsync high -> eol and eof same cycle, err_line_cnt=1.
REQ-037 rst_n low 2 cycles mid-line 1, then full frame -> no strobes from aborted frame, next frame clean, frame_cnt=1.
REQ-038 CRC_EN, single line of ASCII "123456789" (IMG_WIDTH=9, IMG_HEIGHT=1) -> frame_crc=0x29B1.
